// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high time and duty of an asynchronous PWM input.
// Duty is computed by a bit-serial restoring divider, one quotient bit per cycle.
// A stuck input is reported by timeout.
module pwm_capture #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DUTY_W     = 10,
  parameter int unsigned MAX_PERIOD = 100_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              timeout,
  output logic              overrun
);

  localparam logic [0:0]        ST_IDLE    = 1'b0;
  localparam logic [0:0]        ST_MEASURE = 1'b1;
  localparam logic [CNT_W-1:0]  MAX_CNT    = CNT_W'(MAX_PERIOD);
  localparam int unsigned       IT_W       = $clog2(DUTY_W + 1);
  localparam logic [IT_W-1:0]   ITERS      = IT_W'(DUTY_W);
  localparam logic [DUTY_W-1:0] DUTY_MAX   = '1;

  logic              r_sync1, r_sync2, r_sync_d;
  logic [0:0]        r_state;
  logic [CNT_W-1:0]  r_cnt, r_hcnt;
  logic              r_fell;
  logic              r_busy, r_sat;
  logic [IT_W-1:0]   r_iter;
  logic [CNT_W-1:0]  r_rem, r_p, r_h;
  logic [DUTY_W-2:0] r_q;
  logic [CNT_W-1:0]  r_period, r_high_time;
  logic [DUTY_W-1:0] r_duty;
  logic              r_valid, r_timeout, r_overrun;

  logic              w_s, w_rise, w_measuring, w_to_hit, w_start, w_collide, w_last;
  logic [CNT_W:0]    w_rem_sh;
  logic              w_sub_ok;
  logic [CNT_W-1:0]  w_rem_nx;
  logic [DUTY_W-1:0] w_q_nx;

  assign w_s         = r_sync2;
  assign w_rise      = r_sync2 & ~r_sync_d;
  assign w_measuring = (r_state == ST_MEASURE);
  // A rise coinciding with the saturation cycle is a normal measurement.
  assign w_to_hit    = w_measuring & ~w_rise & (r_cnt == MAX_CNT);
  assign w_start     = w_measuring & w_rise & ~r_busy;
  assign w_collide   = w_measuring & w_rise & r_busy;
  assign w_last      = r_busy & (r_iter == IT_W'(1));

  // One restoring-division step: the remainder stays below the divisor, so it fits CNT_W bits.
  assign w_rem_sh = {r_rem, 1'b0};
  assign w_sub_ok = (w_rem_sh >= {1'b0, r_p});
  assign w_rem_nx = w_sub_ok ? CNT_W'(w_rem_sh - {1'b0, r_p}) : CNT_W'(w_rem_sh);
  assign w_q_nx   = {r_q, w_sub_ok};

  // Two-flop synchronizer plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= pwm_in;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  // Measurement FSM: period and high-time counters restarted on every rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hcnt  <= '0;
      r_fell  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state <= ST_MEASURE;
            r_cnt   <= CNT_W'(1);
            r_hcnt  <= CNT_W'(1);
            r_fell  <= 1'b0;
          end
        end
        ST_MEASURE: begin
          if (w_rise) begin
            r_cnt  <= CNT_W'(1);
            r_hcnt <= CNT_W'(1);
            r_fell <= 1'b0;
          end else if (w_to_hit) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hcnt  <= '0;
            r_fell  <= 1'b0;
          end else begin
            if (r_cnt != MAX_CNT) r_cnt <= r_cnt + CNT_W'(1);
            if (w_s && !r_fell)   r_hcnt <= r_hcnt + CNT_W'(1);
            if (!w_s)             r_fell <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Divider sequencing and result registers; timeout overrides and aborts any divide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy      <= 1'b0;
      r_sat       <= 1'b0;
      r_iter      <= '0;
      r_rem       <= '0;
      r_p         <= '0;
      r_h         <= '0;
      r_q         <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_duty      <= '0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_to_hit) begin
        r_busy      <= 1'b0;
        r_iter      <= '0;
        r_valid     <= 1'b1;
        r_timeout   <= 1'b1;
        r_period    <= '0;
        r_duty      <= w_s ? DUTY_MAX : '0;
        r_high_time <= w_s ? MAX_CNT : '0;
      end else if (r_busy) begin
        r_rem  <= w_rem_nx;
        r_q    <= w_q_nx[DUTY_W-2:0];
        r_iter <= r_iter - IT_W'(1);
        if (w_last) begin
          r_busy      <= 1'b0;
          r_valid     <= 1'b1;
          r_timeout   <= 1'b0;
          r_period    <= r_p;
          r_high_time <= r_h;
          r_duty      <= r_sat ? DUTY_MAX : w_q_nx;
        end
      end
      if (w_start) begin
        r_busy <= 1'b1;
        r_iter <= ITERS;
        r_rem  <= r_hcnt;
        r_q    <= '0;
        r_sat  <= (r_hcnt >= r_cnt);
        r_p    <= r_cnt;
        r_h    <= r_hcnt;
      end
    end
  end

  // Sticky flag: an edge arrived before the previous divide finished.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_collide) begin
      r_overrun <= 1'b1;
    end
  end

  assign period    = r_period;
  assign high_time = r_high_time;
  assign duty      = r_duty;
  assign valid     = r_valid;
  assign timeout   = r_timeout;
  assign overrun   = r_overrun;

endmodule
